// File: rtl/dbus_master.sv
// Data-bus master: turns one pipeline load/store request into a single MREQ/ACKD_n
// bus cycle with a wait timeout, then returns a one-cycle response.
module dbus_master #(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  inout  wire  [BIT_WIDTH-1:0] DDT,
  input  logic                 ACKD_n
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t               state_q, state_d;
  logic                 mreq_q, mreq_d;
  logic                 write_q, write_d;
  logic [1:0]           size_q, size_d;
  logic [BIT_WIDTH-1:0] dad_q, dad_d;
  logic [BIT_WIDTH-1:0] wdata_q, wdata_d;
  logic                 uns_q, uns_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [BIT_WIDTH-1:0] rdata_q, rdata_d;

  logic                 req_bad;
  logic [BIT_WIDTH-1:0] wdata_shaped;
  logic [BIT_WIDTH-1:0] load_ext;

  assign req_bad = (req_size == 2'b11) ||
                   (req_size == 2'b00 && req_addr[1:0] != 2'b00) ||
                   (req_size == 2'b01 && req_addr[0]);

  always_comb begin
    case (req_size)
      2'b01:   wdata_shaped = {{(BIT_WIDTH-16){1'b0}}, req_wdata[15:0]};
      2'b10:   wdata_shaped = {{(BIT_WIDTH-8){1'b0}}, req_wdata[7:0]};
      default: wdata_shaped = req_wdata;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b01:   load_ext = {{(BIT_WIDTH-16){~uns_q & DDT[15]}}, DDT[15:0]};
      2'b10:   load_ext = {{(BIT_WIDTH-8){~uns_q & DDT[7]}}, DDT[7:0]};
      default: load_ext = DDT;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mreq_d  = mreq_q;
    write_d = write_q;
    size_d  = size_q;
    dad_d   = dad_q;
    wdata_d = wdata_q;
    uns_d   = uns_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            mreq_d  = 1'b1;
            write_d = req_write;
            size_d  = req_size;
            dad_d   = req_addr;
            wdata_d = wdata_shaped;
            uns_d   = req_unsigned;
            cnt_d   = '0;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (!ACKD_n || cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Ack wins over a timeout that lands on the same edge.
          err_d   = ACKD_n;
          rdata_d = (!ACKD_n && !write_q) ? load_ext : '0;
          mreq_d  = 1'b0;
          write_d = 1'b0;
          size_d  = 2'b00;
          dad_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        err_d   = 1'b0;
        rdata_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      mreq_q  <= 1'b0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      dad_q   <= '0;
      wdata_q <= '0;
      uns_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      mreq_q  <= mreq_d;
      write_q <= write_d;
      size_q  <= size_d;
      dad_q   <= dad_d;
      wdata_q <= wdata_d;
      uns_q   <= uns_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;
  assign MREQ       = mreq_q;
  assign WRITE      = write_q;
  assign SIZE       = size_q;
  assign DAD        = dad_q;
  assign DDT        = (state_q == BUS && write_q) ? wdata_q : {BIT_WIDTH{1'bz}};

endmodule
